// File: rtl/superh16_int_div_unit_if.sv
// Issue and writeback handshake bundle for the integer divide unit.
// master = scheduler/writeback side, slave = the divide unit.
interface superh16_int_div_unit_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned PHYS_REG_BITS = 10,
    parameter int unsigned ROB_IDX_BITS  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               in_opcode;
    logic [XLEN-1:0]          in_src1;
    logic [XLEN-1:0]          in_src2;
    logic [PHYS_REG_BITS-1:0] in_dst_tag;
    logic [ROB_IDX_BITS-1:0]  in_rob_idx;

    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_result;
    logic [PHYS_REG_BITS-1:0] out_dst_tag;
    logic [ROB_IDX_BITS-1:0]  out_rob_idx;
    logic                     out_exception;
    logic [7:0]               out_exception_code;

    modport master (
        output in_valid, in_opcode, in_src1, in_src2, in_dst_tag, in_rob_idx, out_ready,
        input  in_ready, out_valid, out_result, out_dst_tag, out_rob_idx, out_exception,
               out_exception_code
    );

    modport slave (
        input  in_valid, in_opcode, in_src1, in_src2, in_dst_tag, in_rob_idx, out_ready,
        output in_ready, out_valid, out_result, out_dst_tag, out_rob_idx, out_exception,
               out_exception_code
    );
endinterface

// File: rtl/superh16_int_div_unit.sv
// Iterative restoring integer divide/remainder unit, one op in flight,
// BITS_PER_CYCLE quotient bits retired per cycle.
module superh16_int_div_unit #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned PHYS_REG_BITS  = 10,
    parameter int unsigned ROB_IDX_BITS   = 8,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    superh16_int_div_unit_if.slave div_if
);
    localparam int unsigned N    = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [6:0] UopDiv  = 7'd14;
    localparam logic [6:0] UopDivu = 7'd15;
    localparam logic [6:0] UopRem  = 7'd16;
    localparam logic [6:0] UopRemu = 7'd17;

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                   state_q, state_d;
    logic [XLEN:0]            rem_q;
    logic [XLEN-1:0]          quo_q;
    logic [XLEN-1:0]          divisor_q;
    logic [CntW-1:0]          cnt_q;
    logic                     neg_quo_q, neg_rem_q, is_rem_q;
    logic [XLEN-1:0]          result_q;
    logic [PHYS_REG_BITS-1:0] tag_q;
    logic [ROB_IDX_BITS-1:0]  rob_q;
    logic                     exc_q;

    logic                     accept, finish;
    logic                     op_div, op_divu, op_rem, op_remu;
    logic                     op_legal, op_signed, op_is_rem;
    logic                     div_zero, overflow, special;
    logic [XLEN-1:0]          src1, src2, abs1, abs2, special_res;
    logic [XLEN:0]            step_rem;
    logic [XLEN-1:0]          step_quo;
    logic [XLEN-1:0]          quo_fin, rem_fin;

    assign div_if.in_ready = (state_q == StIdle) & ~flush;
    assign accept          = div_if.in_valid & div_if.in_ready;

    // Issue-side decode and the single-cycle special-case results.
    always_comb begin
        src1      = div_if.in_src1;
        src2      = div_if.in_src2;
        op_div    = (div_if.in_opcode == UopDiv);
        op_divu   = (div_if.in_opcode == UopDivu);
        op_rem    = (div_if.in_opcode == UopRem);
        op_remu   = (div_if.in_opcode == UopRemu);
        op_legal  = op_div | op_divu | op_rem | op_remu;
        op_signed = op_div | op_rem;
        op_is_rem = op_rem | op_remu;
        div_zero  = (src2 == '0);
        overflow  = op_signed & (src1 == MinInt) & (src2 == '1);
        special   = ~op_legal | div_zero | overflow;
        abs1      = (op_signed & src1[XLEN-1]) ? -src1 : src1;
        abs2      = (op_signed & src2[XLEN-1]) ? -src2 : src2;
        if (!op_legal) begin
            special_res = '0;
        end else if (div_zero) begin
            special_res = op_is_rem ? src1 : '1;
        end else begin
            special_res = op_is_rem ? '0 : src1;
        end
    end

    // BITS_PER_CYCLE restoring steps, MSB of the dividend first.
    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (step_rem >= {1'b0, divisor_q}) begin
                step_rem    = step_rem - {1'b0, divisor_q};
                step_quo[0] = 1'b1;
            end
        end
        quo_fin = neg_quo_q ? -step_quo : step_quo;
        rem_fin = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: if (accept) state_d = special ? StDone : StBusy;
            StBusy: begin
                if (cnt_q == CntW'(N - 1)) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: if (div_if.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
            tag_q     <= '0;
            rob_q     <= '0;
            exc_q     <= 1'b0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= abs1;
            divisor_q <= abs2;
            cnt_q     <= '0;
            neg_quo_q <= op_signed & (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_rem_q <= op_signed & src1[XLEN-1];
            is_rem_q  <= op_is_rem;
            tag_q     <= div_if.in_dst_tag;
            rob_q     <= div_if.in_rob_idx;
            exc_q     <= ~op_legal;
            if (special) result_q <= special_res;
        end else if (state_q == StBusy) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + CntW'(1);
            if (finish) result_q <= is_rem_q ? rem_fin : quo_fin;
        end
    end

    assign div_if.out_valid          = (state_q == StDone);
    assign div_if.out_result         = result_q;
    assign div_if.out_dst_tag        = tag_q;
    assign div_if.out_rob_idx        = rob_q;
    assign div_if.out_exception      = exc_q;
    assign div_if.out_exception_code = exc_q ? 8'd2 : 8'd0;
endmodule

// File: tb/tb_superh16_int_div_unit.sv
// Scoreboard bench for superh16_int_div_unit: the driver queues expected results at
// accept time, a negedge monitor pops and checks whenever out_valid appears.
module tb_superh16_int_div_unit;
    localparam int unsigned XLEN = 64;
    localparam int unsigned PRB  = 10;
    localparam int unsigned RIB  = 8;

    localparam logic [6:0] UopDiv  = 7'd14;
    localparam logic [6:0] UopDivu = 7'd15;
    localparam logic [6:0] UopRem  = 7'd16;
    localparam logic [6:0] UopRemu = 7'd17;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    superh16_int_div_unit_if #(.XLEN(XLEN), .PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB)) dif ();

    superh16_int_div_unit #(
        .XLEN          (XLEN),
        .PHYS_REG_BITS (PRB),
        .ROB_IDX_BITS  (RIB),
        .BITS_PER_CYCLE(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .div_if(dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [9:0]  tag;
        logic [7:0]  rob;
        logic        exc;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: first out_valid cycle of a result is checked against the queue head,
    // later cycles of the same result must hold their values.
    logic        seen = 1'b0;
    exp_t        cur;
    logic [63:0] snap_res;
    logic [9:0]  snap_tag;
    logic [7:0]  snap_rob;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (dif.out_valid) begin
                if (!seen) begin
                    seen     = 1'b1;
                    snap_res = dif.out_result;
                    snap_tag = dif.out_dst_tag;
                    snap_rob = dif.out_rob_idx;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_result: got out_valid=1 result=0x%0h, expected none",
                                 dif.out_result);
                    end else begin
                        cur = sb.pop_front();
                        check("result", dif.out_result, cur.res);
                        check("dst_tag", 64'(dif.out_dst_tag), 64'(cur.tag));
                        check("rob_idx", 64'(dif.out_rob_idx), 64'(cur.rob));
                        check("exception", 64'(dif.out_exception), 64'(cur.exc));
                        check("exc_code", 64'(dif.out_exception_code), cur.exc ? 64'd2 : 64'd0);
                        check("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
                    end
                end else begin
                    check("stable_result", dif.out_result, snap_res);
                    check("stable_tag", 64'(dif.out_dst_tag), 64'(snap_tag));
                    check("stable_rob", 64'(dif.out_rob_idx), 64'(snap_rob));
                end
                if (dif.out_ready || flush) seen = 1'b0;
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [9:0] tag, input logic [7:0] rob, input logic expect_out,
                         input logic [63:0] res, input logic exc, input int lat);
        exp_t e;
        logic rdy;
        int   tries;
        tries          = 0;
        rdy            = 1'b0;
        dif.in_valid   = 1'b1;
        dif.in_opcode  = op;
        dif.in_src1    = a;
        dif.in_src2    = b;
        dif.in_dst_tag = tag;
        dif.in_rob_idx = rob;
        forever begin
            @(negedge clk);
            rdy = dif.in_ready;
            @(posedge clk);
            if (rdy) break;
            tries++;
            if (tries > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL issue_timeout: got in_ready=0 for 100 cycles, expected accept");
                break;
            end
        end
        #1;
        dif.in_valid = 1'b0;
        if (rdy && expect_out) begin
            e.res = res;
            e.tag = tag;
            e.rob = rob;
            e.exc = exc;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic expect_quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            check("quiet_out_valid", 64'(dif.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int  tries;
        logic done;
        tries = 0;
        done  = 1'b0;
        while (!done && tries < 100) begin
            @(negedge clk);
            if (sb.size() == 0 && !dif.out_valid && dif.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
        end
    endtask

    initial begin
        int tries;
        dif.in_valid   = 1'b0;
        dif.in_opcode  = '0;
        dif.in_src1    = '0;
        dif.in_src2    = '0;
        dif.in_dst_tag = '0;
        dif.in_rob_idx = '0;
        dif.out_ready  = 1'b1;

        #12;
        check("reset_in_ready", 64'(dif.in_ready), 64'd1);
        check("reset_out_valid", 64'(dif.out_valid), 64'd0);
        check("reset_result", dif.out_result, 64'd0);
        check("reset_exception", 64'(dif.out_exception), 64'd0);
        check("reset_exc_code", 64'(dif.out_exception_code), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Normal and special-case vectors, issued back to back.
        issue(UopDiv, 64'd100, 64'd7, 10'h155, 8'h21, 1'b1, 64'd14, 1'b0, 17);
        issue(UopRem, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 10'h001, 8'h02, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 17);
        issue(UopDiv, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 10'h002, 8'h03, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 17);
        issue(UopDivu, 64'h1234, 64'd0, 10'h003, 8'h04, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        issue(UopRemu, 64'h1234, 64'd0, 10'h004, 8'h05, 1'b1, 64'h1234, 1'b0, 1);
        issue(UopDiv, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 10'h005, 8'h06, 1'b1,
              64'h8000_0000_0000_0000, 1'b0, 1);
        issue(UopRem, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 10'h006, 8'h07, 1'b1,
              64'd0, 1'b0, 1);
        issue(UopDiv, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 10'h007, 8'h08, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 17);
        issue(UopRem, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 10'h008, 8'h09, 1'b1, 64'd2, 1'b0, 17);
        issue(UopRem, 64'hFFFF_FFFF_FFFF_FFD6, 64'd7, 10'h009, 8'h0A, 1'b1, 64'd0, 1'b0, 17);
        issue(UopRemu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 10'h00A, 8'h0B, 1'b1, 64'd5, 1'b0, 17);
        issue(7'd1, 64'd5, 64'd3, 10'h3FF, 8'hFF, 1'b1, 64'd0, 1'b1, 1);
        wait_drain();

        // Backpressure: result held for 5 cycles with out_ready low.
        dif.out_ready = 1'b0;
        issue(UopDivu, 64'd1000, 64'd10, 10'h0AB, 8'h5C, 1'b1, 64'd100, 1'b0, 17);
        tries = 0;
        do begin
            @(negedge clk);
            tries++;
        end while (!dif.out_valid && tries < 40);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_in_ready", 64'(dif.in_ready), 64'd0);
            check("bp_out_valid", 64'(dif.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_after", 64'(dif.in_ready), 64'd1);
        check("bp_valid_after", 64'(dif.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Flush during BUSY cycle 6 kills the op.
        wait_drain();
        issue(UopDiv, 64'd1000, 64'd3, 10'h011, 8'h12, 1'b0, 64'd0, 1'b0, 0);
        step(5);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(dif.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("ready_after_flush", 64'(dif.in_ready), 64'd1);
        @(posedge clk);
        #1;
        expect_quiet(14);
        issue(UopDivu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 10'h013, 8'h14, 1'b1,
              64'h5555_5555_5555_5555, 1'b0, 17);
        wait_drain();

        // Flush alongside in_valid: op must not be accepted.
        flush          = 1'b1;
        dif.in_valid   = 1'b1;
        dif.in_opcode  = UopDivu;
        dif.in_src1    = 64'd5;
        dif.in_src2    = 64'd0;
        @(negedge clk);
        check("flush_valid_ready", 64'(dif.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        dif.in_valid = 1'b0;
        expect_quiet(3);

        // Reset mid-operation.
        issue(UopDiv, 64'd12345, 64'd7, 10'h015, 8'h16, 1'b0, 64'd0, 1'b0, 0);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(dif.out_valid), 64'd0);
        check("midreset_in_ready", 64'(dif.in_ready), 64'd1);
        check("midreset_result", dif.out_result, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_quiet(18);

        wait_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/superh16_int_div_unit.md
Name: superh16_int_div_unit

Overview:
- Iterative integer divide/remainder execution unit on one EXEC_INT_DIV issue port.
- Consumes issued micro-ops from the scheduler: opcode, two 64-bit source operands, destination tag, ROB index.
- Produces one result per operation on a valid/ready port toward writeback/ROB completion.
- Non-pipelined: holds one operation at a time and retires BITS_PER_CYCLE quotient bits per cycle.

Parameters:
- XLEN, 64, operand/result width
- PHYS_REG_BITS, 10, destination tag width
- ROB_IDX_BITS, 8, ROB index width
- BITS_PER_CYCLE, 4, quotient bits per iteration; must divide XLEN (legal values 1, 2, 4, 8)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills any in-flight or pending op
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept an op
- in_opcode  in  7  uop_opcode_t: UOP_DIV=14, DIVU=15, REM=16, REMU=17
- in_src1  in  XLEN  dividend
- in_src2  in  XLEN  divisor
- in_dst_tag  in  PHYS_REG_BITS  destination physical register
- in_rob_idx  in  ROB_IDX_BITS  ROB index
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  XLEN  quotient or remainder
- out_dst_tag  out  PHYS_REG_BITS  captured in_dst_tag
- out_rob_idx  out  ROB_IDX_BITS  captured in_rob_idx
- out_exception  out  1  illegal opcode reached unit
- out_exception_code  out  8  8'd2 when out_exception=1, else 0

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset: IDLE.
- Output reset values: in_ready=1, out_valid=0, all other outputs 0.
- in_ready = (state==IDLE) & ~flush. Accept = in_valid & in_ready.
- On accept, capture operands, opcode, tag, rob_idx.
  - Signed ops (DIV, REM): operate on absolute values; record quotient sign = sign1^sign2 and remainder sign = sign1.
- Special cases go IDLE->DONE in one cycle (out_valid at T+1 for accept at T):
  - Divisor==0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (src1=0x8000_0000_0000_0000, src2=-1): DIV gives src1; REM gives 0.
  - Opcode outside 14..17: out_exception=1, code 2, result 0.
- Normal case: IDLE->BUSY.
  - Restoring division: each cycle retires BITS_PER_CYCLE bits, MSB first; partial remainder is XLEN+1 bits.
  - Iteration counter counts N = XLEN/BITS_PER_CYCLE cycles.
  - After the Nth iteration, sign-correct (two's-complement negate where the recorded sign is 1) and register the result; state -> DONE.
  - out_valid first asserts at T+1+N (T+17 at defaults).
- DONE: out_valid=1; all out_* stable until out_ready=1, then IDLE the next cycle. No accept in the same cycle as a DONE handshake.
- Unsigned ops never negate. REM result takes the dividend's sign; zero remainder stays 0.
- flush (any state): next state IDLE, out_valid=0 next cycle. Contents are discarded.
  - flush in the same cycle as in_valid: op not accepted (in_ready forced low).
  - flush in the same cycle as an out_ready handshake: the result counts as delivered; state -> IDLE.
- Reset mid-operation: immediate return to reset values; no output.
- out_* fields are don't-care when out_valid=0 but must not glitch while out_valid=1.

Test Plan:
- DIV src1=100, src2=7 accepted at T -> out_valid at T+17, out_result=14, tag/rob_idx echoed, out_exception=0.
- REM src1=-100 (0xFFFF_FFFF_FFFF_FF9C), src2=7 -> out_result=0xFFFF_FFFF_FFFF_FFFE (-2). DIV same operands -> 0xFFFF_FFFF_FFFF_FFF2 (-14).
- DIVU src1=0x1234, src2=0 -> out_result=0xFFFF_FFFF_FFFF_FFFF at T+1. REMU same -> 0x1234.
- DIV src1=0x8000_0000_0000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> out_result=0x8000_0000_0000_0000 at T+1. REM same -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. Raise out_ready -> in_ready=1 the following cycle.
- Flush at BUSY cycle 6 -> out_valid never asserts, in_ready=1 the next cycle. A new DIVU 0xFFFF_FFFF_FFFF_FFFF/3 then yields 0x5555_5555_5555_5555. Opcode UOP_ADD -> out_exception=1, code 2 at T+1.
